alien_march_ctrl: RTL and testbench
===================================

// Module: alien_march_ctrl
// PURPOSE
//   Consumes the one-cycle tick pulse from the clock divider and advances the alien
//   formation's position offset. The formation marches horizontally and drops one row
//   at each screen edge. It then reverses direction. It freezes when it reaches the
//   landing row. Outputs feed the sprite renderer and game-over logic.
// PARAMETERS
//   X_W      10   width of x_off
//   Y_W      10   width of y_off
//   X_MIN    0    leftmost allowed x_off
//   X_MAX    224  rightmost allowed x_off
//   X_STEP   4    pixels moved per horizontal tick
//   Y_START  32   y_off after reset
//   Y_STEP   16   pixels descended per drop
//   Y_LIMIT  400  landing threshold on y_off
// PORTS
//   clk          in   1    100 MHz system clock
//   rst          in   1    synchronous, active-high reset
//   tick         in   1    one-cycle move strobe from the clock divider
//   pause        in   1    high = ignore tick; hold all state
//   x_off        out  X_W  formation x offset (registered)
//   y_off        out  Y_W  formation y offset (registered)
//   dir          out  1    0 = marching right, 1 = marching left
//   frame        out  1    animation frame select; toggles on every move
//   moved        out  1    one-cycle pulse, coincident with any x_off/y_off update
//   landed       out  1    sticky; high once y_off >= Y_LIMIT
// BEHAVIOUR
//   - Reset (rst high at posedge, overrides everything): state=RIGHT, x_off=X_MIN,
//     y_off=Y_START, dir=0, frame=0, moved=0, landed=0. tick during rst is ignored.
//   - FSM states: RIGHT, LEFT, LANDED. A "step" means tick=1 and pause=0 in state
//     RIGHT or LEFT. In LANDED, tick is ignored and all outputs hold. moved stays 0.
//   - RIGHT step: if x_off + X_STEP <= X_MAX, then x_off += X_STEP.
//     Otherwise drop: x_off holds, y_off += Y_STEP, dir<=1, state<=LEFT.
//   - LEFT step: if x_off >= X_MIN + X_STEP, then x_off -= X_STEP.
//     Otherwise drop: x_off holds, y_off += Y_STEP, dir<=0, state<=RIGHT.
//   - A drop replaces that tick's horizontal move (never both in one tick).
//   - Landing: if the y_off produced by a drop is >= Y_LIMIT, then state<=LANDED
//     and landed<=1 in the same cycle the new y_off appears.
//   - Every step toggles frame and asserts moved for exactly one cycle.
//     When there is no step, moved=0.
//   - Latency: outputs reflect a tick on the clock edge after the tick cycle
//     (1-cycle registered). Back-to-back ticks on consecutive cycles each produce
//     a step.
//   - Arithmetic: edge compares use X_W+1 bits, so x_off + X_STEP never wraps.
//     The y add uses Y_W+1 bits. If it would overflow Y_W, y_off saturates at
//     all-ones and the formation lands.
//   - pause=1 with tick=1: no step, no moved pulse. That tick is lost, not deferred.
//   - Reset mid-march: the next cycle shows reset values regardless of state.
// TESTING
//   1. Reset -> x_off=0, y_off=32, dir=0, frame=0, moved=0, landed=0;
//      tick held high during rst -> no change.
//   2. X_MAX=12, ticks 1-3 -> x_off=4,8,12 and moved pulses 3x.
//      Tick 4 -> x_off=12, y_off=48, dir=1.
//      Tick 5 -> x_off=8.
//   3. LEFT at x_off=0, tick -> y_off += 16, dir=0, x_off=0.
//      Next tick -> x_off=4.
//   4. Y_LIMIT=64, march until the second drop -> y_off=64, landed=1.
//      Further ticks -> all outputs frozen, moved=0.
//   5. pause=1 with 5 ticks -> outputs unchanged.
//      Release pause, 1 tick -> exactly one step. Frame toggles once.
//   6. Ticks on 3 consecutive cycles -> 3 steps with 3 moved pulses.
//      rst asserted mid-march -> reset values on the next cycle.

Source files
------------

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller: steps the formation offset on each divider tick,
// drops a row and reverses at the screen edges, and freezes once the landing row is reached.
module alien_march_ctrl #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 224,
  parameter int X_STEP  = 4,
  parameter int Y_START = 32,
  parameter int Y_STEP  = 16,
  parameter int Y_LIMIT = 400
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           pause,
  output logic [X_W-1:0] x_off,
  output logic [Y_W-1:0] y_off,
  output logic           dir,
  output logic           frame,
  output logic           moved,
  output logic           landed
);

  // state    | meaning
  // S_RIGHT  | marching toward X_MAX
  // S_LEFT   | marching toward X_MIN
  // S_LANDED | reached landing row; everything frozen until reset
  typedef enum logic [1:0] {S_RIGHT, S_LEFT, S_LANDED} state_t;

  localparam logic [X_W:0]   STEP_X   = (X_W+1)'(X_STEP);
  localparam logic [X_W:0]   MAX_X    = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]   LEFT_LIM = (X_W+1)'(X_MIN + X_STEP);
  localparam logic [Y_W:0]   STEP_Y   = (Y_W+1)'(Y_STEP);
  localparam logic [31:0]    Y_LIM32  = 32'(Y_LIMIT);

  state_t         state, state_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           dir_nxt, frame_nxt, moved_nxt, landed_nxt;

  logic [X_W:0]   x_ext, x_sum, x_dif;
  logic [Y_W:0]   y_sum;
  logic [Y_W-1:0] y_drop;
  logic           drop_lands, step;

  assign x_ext  = {1'b0, x_off};
  assign x_sum  = x_ext + STEP_X;
  assign x_dif  = x_ext - STEP_X;
  assign y_sum  = {1'b0, y_off} + STEP_Y;
  // An overflowing drop pins y_off at all-ones and always counts as a landing.
  assign y_drop = y_sum[Y_W] ? '1 : y_sum[Y_W-1:0];
  assign drop_lands = y_sum[Y_W] || (32'(y_drop) >= Y_LIM32);
  assign step   = tick && !pause && (state != S_LANDED);

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_off;
    y_nxt      = y_off;
    dir_nxt    = dir;
    frame_nxt  = frame;
    moved_nxt  = 1'b0;
    landed_nxt = landed;
    if (step) begin
      moved_nxt = 1'b1;
      frame_nxt = ~frame;
      case (state)
        S_RIGHT: begin
          if (x_sum <= MAX_X) begin
            x_nxt = x_sum[X_W-1:0];
          end else begin
            y_nxt      = y_drop;
            dir_nxt    = 1'b1;
            state_nxt  = drop_lands ? S_LANDED : S_LEFT;
            landed_nxt = drop_lands;
          end
        end
        S_LEFT: begin
          if (x_ext >= LEFT_LIM) begin
            x_nxt = x_dif[X_W-1:0];
          end else begin
            y_nxt      = y_drop;
            dir_nxt    = 1'b0;
            state_nxt  = drop_lands ? S_LANDED : S_RIGHT;
            landed_nxt = drop_lands;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RIGHT;
      x_off  <= X_W'(X_MIN);
      y_off  <= Y_W'(Y_START);
      dir    <= 1'b0;
      frame  <= 1'b0;
      moved  <= 1'b0;
      landed <= 1'b0;
    end else begin
      state  <= state_nxt;
      x_off  <= x_nxt;
      y_off  <= y_nxt;
      dir    <= dir_nxt;
      frame  <= frame_nxt;
      moved  <= moved_nxt;
      landed <= landed_nxt;
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed bench for alien_march_ctrl: three instances share stimulus (narrow playfield,
// low landing row, and a narrow y register that saturates on its second drop).
module tb_alien_march_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic pause = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x_a, y_a, x_b, y_b, x_c;
  logic [5:0] y_c;
  logic dir_a, frame_a, moved_a, landed_a;
  logic dir_b, frame_b, moved_b, landed_b;
  logic dir_c, frame_c, moved_c, landed_c;

  alien_march_ctrl #(.X_MAX(12)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .x_off(x_a), .y_off(y_a),
    .dir(dir_a), .frame(frame_a), .moved(moved_a), .landed(landed_a));

  alien_march_ctrl #(.X_MAX(12), .Y_LIMIT(64)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .x_off(x_b), .y_off(y_b),
    .dir(dir_b), .frame(frame_b), .moved(moved_b), .landed(landed_b));

  alien_march_ctrl #(.X_MAX(12), .Y_W(6)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .x_off(x_c), .y_off(y_c),
    .dir(dir_c), .frame(frame_c), .moved(moved_c), .landed(landed_c));

  logic [23:0] st_a, st_b;
  logic [19:0] st_c;
  assign st_a = {x_a, y_a, dir_a, frame_a, moved_a, landed_a};
  assign st_b = {x_b, y_b, dir_b, frame_b, moved_b, landed_b};
  assign st_c = {x_c, y_c, dir_c, frame_c, moved_c, landed_c};

  int total = 0;
  int bad = 0;

  // Packs expected {x, y, dir, frame, moved, landed} in the same order as st_a/st_b.
  function automatic logic [23:0] ex(int x, int y, bit d, bit f, bit m, bit l);
    return {10'(x), 10'(y), d, f, m, l};
  endfunction

  task automatic do_reset(input bit hold_tick);
    @(negedge clk);
    rst = 1'b1;
    tick = hold_tick;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    do_reset(1'b1);
    e = ex(0, 32, 0, 0, 0, 0);
    if (st_a !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", st_a, e); end
    total++;
    if (st_c !== {10'd0, 6'd32, 4'b0000}) begin
      bad++; $display("FAIL reset_c got=%h exp=%h", st_c, {10'd0, 6'd32, 4'b0000});
    end
    total++;
    @(negedge clk);
    if (st_b !== e) begin bad++; $display("FAIL reset_idle_b got=%h exp=%h", st_b, e); end
    total++;
  endtask

  task automatic test_march_right();
    int xs[5] = '{4, 8, 12, 12, 8};
    int ys[5] = '{32, 32, 32, 48, 48};
    bit ds[5] = '{0, 0, 0, 1, 1};
    logic [23:0] e;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      e = ex(xs[i], ys[i], ds[i], ((i + 1) % 2) == 1, 1, 0);
      if (st_a !== e) begin bad++; $display("FAIL right_tick%0d got=%h exp=%h", i + 1, st_a, e); end
      total++;
    end
  endtask

  task automatic test_march_left();
    int xs[4] = '{4, 0, 0, 4};
    int ys[4] = '{48, 48, 64, 64};
    bit ds[4] = '{1, 1, 0, 0};
    bit fs[4] = '{0, 1, 0, 1};
    logic [23:0] e;
    for (int i = 0; i < 4; i++) begin
      do_tick();
      e = ex(xs[i], ys[i], ds[i], fs[i], 1, 0);
      if (st_a !== e) begin bad++; $display("FAIL left_tick%0d got=%h exp=%h", i + 6, st_a, e); end
      total++;
    end
    @(negedge clk);
    e = ex(4, 64, 0, 1, 0, 0);
    if (st_a !== e) begin bad++; $display("FAIL left_idle got=%h exp=%h", st_a, e); end
    total++;
  endtask

  task automatic test_landing();
    logic [23:0] e;
    do_reset(1'b0);
    repeat (4) do_tick();
    e = ex(12, 48, 1, 0, 1, 0);
    if (st_b !== e) begin bad++; $display("FAIL land_drop1 got=%h exp=%h", st_b, e); end
    total++;
    repeat (4) do_tick();
    e = ex(0, 64, 0, 0, 1, 1);
    if (st_b !== e) begin bad++; $display("FAIL land_drop2 got=%h exp=%h", st_b, e); end
    total++;
    if (st_c !== {10'd0, 6'd63, 4'b0011}) begin
      bad++; $display("FAIL land_sat got=%h exp=%h", st_c, {10'd0, 6'd63, 4'b0011});
    end
    total++;
    e = ex(0, 64, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      if (st_b !== e) begin bad++; $display("FAIL land_frozen%0d got=%h exp=%h", i, st_b, e); end
      total++;
    end
    if (st_c !== {10'd0, 6'd63, 4'b0001}) begin
      bad++; $display("FAIL land_sat_frozen got=%h exp=%h", st_c, {10'd0, 6'd63, 4'b0001});
    end
    total++;
  endtask

  task automatic test_pause();
    logic [23:0] e;
    do_reset(1'b0);
    pause = 1'b1;
    e = ex(0, 32, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      if (st_a !== e) begin bad++; $display("FAIL pause_tick%0d got=%h exp=%h", i, st_a, e); end
      total++;
    end
    pause = 1'b0;
    do_tick();
    e = ex(4, 32, 0, 1, 1, 0);
    if (st_a !== e) begin bad++; $display("FAIL pause_release got=%h exp=%h", st_a, e); end
    total++;
    @(negedge clk);
    e = ex(4, 32, 0, 1, 0, 0);
    if (st_a !== e) begin bad++; $display("FAIL pause_after got=%h exp=%h", st_a, e); end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_seq[4];
    logic [23:0] e;
    exp_seq[0] = ex(4, 32, 0, 1, 1, 0);
    exp_seq[1] = ex(8, 32, 0, 0, 1, 0);
    exp_seq[2] = ex(12, 32, 0, 1, 1, 0);
    exp_seq[3] = ex(12, 48, 1, 0, 1, 0);
    do_reset(1'b0);
    @(negedge clk);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (st_a !== exp_seq[i]) begin
        bad++; $display("FAIL b2b_step%0d got=%h exp=%h", i + 1, st_a, exp_seq[i]);
      end
      total++;
    end
    rst = 1'b1;
    @(negedge clk);
    e = ex(0, 32, 0, 0, 0, 0);
    if (st_a !== e) begin bad++; $display("FAIL b2b_midreset got=%h exp=%h", st_a, e); end
    total++;
    rst = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    if (st_a !== e) begin bad++; $display("FAIL b2b_post_reset got=%h exp=%h", st_a, e); end
    total++;
  endtask

  initial begin
    test_reset();
    test_march_right();
    test_march_left();
    test_landing();
    test_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
